// File: rtl/crc16_serial_checker.sv
// crc16_serial_checker
//   Receive-side CRC-16 checker (Galois LFSR, MSB-first). The LFSR runs over
//   the payload bits and the 16 received CRC bits. A good frame leaves a zero
//   residue. The verdict is issued one cycle after frame_end.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   frame_start  one-cycle pulse, opens a new frame (aborts any open frame)
//   bit_valid    bit_in is a frame bit this cycle
//   bit_in       serial data, payload MSB-first then CRC MSB-first
//   frame_end    one-cycle pulse, closes the frame (same-cycle bit included)
//   busy         frame open
//   done         one-cycle pulse, verdict flags valid from this cycle
//   crc_ok       last frame passed (legal length, zero residue), held
//   crc_err      last frame had a non-zero residue with a legal length, held
//   len_err      last frame length outside [MIN_BITS, MAX_BITS], held
//   bit_count    bits accepted in the current/last frame, saturating
//   crc_reg      live LFSR contents
//
// state | meaning
// IDLE  | no frame open, verdict flags held
// RECV  | frame open, bits shifted into the LFSR
// DONE  | one-cycle verdict strobe (done = 1)
module crc16_serial_checker #(
  parameter logic [15:0] POLY     = 16'h1021,
  parameter logic [15:0] INIT     = 16'h0000,
  parameter int          MIN_BITS = 17,
  parameter int          MAX_BITS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        bit_valid,
  input  logic        bit_in,
  input  logic        frame_end,
  output logic        busy,
  output logic        done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        len_err,
  output logic [15:0] bit_count,
  output logic [15:0] crc_reg
);

  localparam logic [15:0] MIN_LEN = 16'(MIN_BITS);
  localparam logic [15:0] MAX_LEN = 16'(MAX_BITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] crc_base, cnt_base, crc_nxt, cnt_nxt;
  logic        shift_en, fb, len_bad, res_bad;
  logic        ok_nxt, err_nxt, len_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ok_nxt    = crc_ok;
    err_nxt   = crc_err;
    len_nxt   = len_err;

    // A frame_start restarts the LFSR from INIT. The same-cycle bit is the first bit.
    crc_base = frame_start ? INIT : crc_reg;
    cnt_base = frame_start ? 16'h0000 : bit_count;
    shift_en = bit_valid & (frame_start | (state == RECV));
    fb       = crc_base[15] ^ bit_in;

    crc_nxt = crc_base;
    cnt_nxt = cnt_base;
    if (shift_en) begin
      crc_nxt = {crc_base[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
      if (cnt_base != 16'hFFFF) cnt_nxt = cnt_base + 16'd1;
    end

    // The verdict uses post-update values so the bit in the frame_end cycle counts.
    len_bad = (cnt_nxt < MIN_LEN) || (cnt_nxt > MAX_LEN);
    res_bad = (crc_nxt != 16'h0000);

    case (state)
      IDLE: state_nxt = IDLE;
      RECV: begin
        if (frame_end) begin
          state_nxt = DONE;
          len_nxt   = len_bad;
          err_nxt   = res_bad & ~len_bad;
          ok_nxt    = ~len_bad & ~res_bad;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // frame_start takes priority over everything, including a same-cycle frame_end.
    if (frame_start) begin
      state_nxt = RECV;
      ok_nxt    = 1'b0;
      err_nxt   = 1'b0;
      len_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_reg   <= INIT;
      bit_count <= 16'h0000;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      crc_reg   <= crc_nxt;
      bit_count <= cnt_nxt;
      crc_ok    <= ok_nxt;
      crc_err   <= err_nxt;
      len_err   <= len_nxt;
    end
  end

  assign busy = (state == RECV);
  assign done = (state == DONE);

endmodule

// File: tb/tb_crc16_serial_checker.sv
module tb_crc16_serial_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start, bit_valid, bit_in, frame_end;
  logic        busy, done, crc_ok, crc_err, len_err;
  logic [15:0] bit_count, crc_reg;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_ref;
  logic [15:0] peek_val;
  logic [127:0] good_frame;

  crc16_serial_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .frame_end  (frame_end),
    .busy       (busy),
    .done       (done),
    .crc_ok     (crc_ok),
    .crc_err    (crc_err),
    .len_err    (len_err),
    .bit_count  (bit_count),
    .crc_reg    (crc_reg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends n bits f[n-1]..f[0]. The first bit carries frame_start. With gap set,
  // bit_valid drops every third cycle. peek captures crc_reg after bit index peek.
  task automatic send(input logic [127:0] f, input int n, input bit gap,
                      input bit with_end, input int peek);
    for (int i = 0; i < n; i++) begin
      if (gap && i != 0 && (i % 2) == 0) begin
        frame_start = 1'b0; bit_valid = 1'b0; frame_end = 1'b0;
        bit_in = 1'($urandom_range(0, 1));
        tick();
      end
      frame_start = (i == 0);
      bit_valid   = 1'b1;
      bit_in      = f[n-1-i];
      frame_end   = with_end && (i == n - 1);
      tick();
      if (i == peek) peek_val = crc_reg;
    end
    frame_start = 1'b0; bit_valid = 1'b0; frame_end = 1'b0; bit_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; frame_end = 1'b0;
    // "123456789" followed by its CRC-16/XMODEM 0x31C3
    good_frame = {40'h0, 72'h313233343536373839, 16'h31C3};
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_crc", 32'(crc_reg), 32'h0000);
    check("rst_flags", 32'({crc_ok, crc_err, len_err}), 32'd0);
    check("rst_count", 32'(bit_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // Good frame
    peek_val = 16'hDEAD;
    send(good_frame, 88, 1'b0, 1'b1, 71);
    check("s1_payload_crc", 32'(peek_val), 32'h31C3);
    check("s1_done", 32'(done), 32'd1);
    check("s1_flags", 32'({crc_ok, crc_err, len_err}), 32'b100);
    check("s1_count", 32'(bit_count), 32'd88);
    check("s1_residue", 32'(crc_reg), 32'h0000);
    check("s1_busy", 32'(busy), 32'd0);
    tick();
    check("s1_done_pulse", 32'(done), 32'd0);
    check("s1_ok_held", 32'(crc_ok), 32'd1);

    // Payload bit 5 inverted
    send(good_frame ^ (128'd1 << (87 - 5)), 88, 1'b0, 1'b1, -1);
    check("s2_done", 32'(done), 32'd1);
    check("s2_flags", 32'({crc_ok, crc_err, len_err}), 32'b010);
    tick();

    // 8'h00 + CRC 0000
    send(128'h0, 24, 1'b0, 1'b1, -1);
    check("s3_flags", 32'({crc_ok, crc_err, len_err}), 32'b100);
    check("s3_count", 32'(bit_count), 32'd24);
    tick();
    // 10-bit zero frame: zero residue but too short
    send(128'h0, 10, 1'b0, 1'b1, -1);
    check("s3_short_done", 32'(done), 32'd1);
    check("s3_short_flags", 32'({crc_ok, crc_err, len_err}), 32'b001);
    check("s3_short_residue", 32'(crc_reg), 32'h0000);
    tick();

    // Gapped bit_valid
    peek_val = 16'hDEAD;
    send(good_frame, 88, 1'b1, 1'b1, 71);
    check("s4_payload_crc", 32'(peek_val), 32'h31C3);
    check("s4_done", 32'(done), 32'd1);
    check("s4_flags", 32'({crc_ok, crc_err, len_err}), 32'b100);
    check("s4_count", 32'(bit_count), 32'd88);
    tick();

    // Abort after 40 bits, then a full good frame
    done_ref = done_cnt;
    send(good_frame >> 48, 40, 1'b0, 1'b0, -1);
    check("s5_busy_mid", 32'(busy), 32'd1);
    check("s5_count_mid", 32'(bit_count), 32'd40);
    send(good_frame, 88, 1'b0, 1'b1, -1);
    check("s5_flags", 32'({crc_ok, crc_err, len_err}), 32'b100);
    tick();
    tick();
    check("s5_one_done", 32'(done_cnt - done_ref), 32'd1);

    // frame_start and frame_end in the same cycle
    done_ref = done_cnt;
    frame_start = 1'b1; frame_end = 1'b1; bit_valid = 1'b0;
    tick();
    frame_start = 1'b0; frame_end = 1'b0;
    check("s6_busy", 32'(busy), 32'd1);
    check("s6_done", 32'(done), 32'd0);
    check("s6_flags_cleared", 32'({crc_ok, crc_err, len_err}), 32'd0);
    tick();
    check("s6_no_done", 32'(done_cnt - done_ref), 32'd0);

    // Reset mid-frame at bit 50
    send(good_frame >> 38, 50, 1'b0, 1'b0, -1);
    check("s7_count_mid", 32'(bit_count), 32'd50);
    done_ref = done_cnt;
    #1 rst_n = 1'b0;
    #1;
    check("s7_rst_busy", 32'(busy), 32'd0);
    check("s7_rst_count", 32'(bit_count), 32'd0);
    check("s7_rst_crc", 32'(crc_reg), 32'h0000);
    #1 rst_n = 1'b1;
    tick();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("s7_end_ignored", 32'(done), 32'd0);
    tick();
    check("s7_no_done", 32'(done_cnt - done_ref), 32'd0);
    send(good_frame, 88, 1'b0, 1'b1, -1);
    check("s7_after_done", 32'(done), 32'd1);
    check("s7_after_flags", 32'({crc_ok, crc_err, len_err}), 32'b100);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
